seven_seg_scan_driver: RTL and testbench

Multiplexed multi-digit seven-segment display driver for the board's display path: accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 engine (or uses hex nibbles directly). Holds the result in a display register and time-multiplexes the digits onto one shared segment bus with per-digit enables. Sits between the arithmetic datapath (adder and counter results) and the board pins. It replaces per-digit combinational decoding by generalising digit count, data width, radix and output polarity.

---
 rtl/seven_seg_scan_driver.sv | 256 +++++++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Accepts a binary value over valid/ready, converts it to BCD with a
// sequential shift-add-3 engine (or takes hex nibbles directly), latches the
// glyphs into a display register and time-multiplexes them onto one shared
// segment bus with one-hot digit enables.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros in
// decimal mode; digit 0 is never blanked).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_DIV   = 100000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  value_valid,
  input  logic [DATA_W-1:0]     value,
  input  logic                  hex_mode,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  // 10**n, evaluated at elaboration for the decimal overflow limit
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

  // Segment pattern {g,f,e,d,c,b,a} for one nibble
  function automatic logic [6:0] glyph7(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b0111111;
      4'h1:    g = 7'b0000110;
      4'h2:    g = 7'b1011011;
      4'h3:    g = 7'b1001111;
      4'h4:    g = 7'b1100110;
      4'h5:    g = 7'b1101101;
      4'h6:    g = 7'b1111101;
      4'h7:    g = 7'b0000111;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1101111;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b1111100;
      4'hC:    g = 7'b0111001;
      4'hD:    g = 7'b1011110;
      4'hE:    g = 7'b1111001;
      4'hF:    g = 7'b1110001;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t                      state_r;
  logic                        ready_r;
  logic                        overflow_r;
  logic                        ovf_pend_r;
  logic [DATA_W-1:0]           bin_r;
  logic [BW-1:0]               bcd_r;
  logic [BW-1:0]               bcd_adj_s;
  logic [CW-1:0]               bit_cnt_r;
  logic [NUM_DIGITS-1:0][6:0]  disp_r;
  logic [NUM_DIGITS-1:0][6:0]  load_glyph_s;
  logic [PW-1:0]               presc_r;
  logic [IW-1:0]               digit_idx_r;
  logic [6:0]                  seg_r;
  logic [NUM_DIGITS-1:0]       an_r;
  logic [NUM_DIGITS-1:0]       an_s;
  logic [BW-1:0]               hex_nib_s;
  logic                        hex_ovf_s;
  logic                        dec_ovf_s;
  logic                        capture_s;
`ifdef LEADING_ZERO_BLANK_EN
  logic                        hex_r;
`endif

  assign capture_s = value_valid && ready_r;
  assign dec_ovf_s = ({{(64-DATA_W){1'b0}}, value} >= DEC_LIMIT);

  // Hex digits are the raw nibbles; anything above the top digit is overflow
  generate
    if (DATA_W >= BW) begin : g_hex_trunc
      assign hex_nib_s = value[BW-1:0];
    end else begin : g_hex_pad
      assign hex_nib_s = {{(BW-DATA_W){1'b0}}, value};
    end
    if (DATA_W > BW) begin : g_hex_ovf
      assign hex_ovf_s = |value[DATA_W-1:BW];
    end else begin : g_hex_noovf
      assign hex_ovf_s = 1'b0;
    end
  endgenerate

  // Add-3 correction of every BCD nibble before the next shift
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
  end

  // Glyphs written into the display register at LOAD
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic seen_nz_s;
    seen_nz_s = 1'b0;
`endif
    load_glyph_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (ovf_pend_r) begin
        load_glyph_s[i] = GLYPH_DASH;
      end
`ifdef LEADING_ZERO_BLANK_EN
      else if (!hex_r && !seen_nz_s && (i != 0) && (bcd_r[4*i +: 4] == 4'd0)) begin
        load_glyph_s[i] = GLYPH_BLANK;
      end
`endif
      else begin
        load_glyph_s[i] = glyph7(bcd_r[4*i +: 4]);
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (bcd_r[4*i +: 4] != 4'd0) begin
        seen_nz_s = 1'b1;
      end else begin
        seen_nz_s = seen_nz_s;
      end
`endif
    end
  end

  // Capture / convert / load sequencer; display only changes at LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ready_r    <= 1'b1;
      overflow_r <= 1'b0;
      ovf_pend_r <= 1'b0;
      bin_r      <= '0;
      bcd_r      <= '0;
      bit_cnt_r  <= '0;
      disp_r     <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      hex_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            ready_r   <= 1'b0;
            bit_cnt_r <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            hex_r     <= hex_mode;
`endif
            if (hex_mode) begin
              bcd_r      <= hex_nib_s;
              bin_r      <= '0;
              ovf_pend_r <= hex_ovf_s;
              state_r    <= LOAD;
            end else begin
              bcd_r      <= '0;
              bin_r      <= value;
              ovf_pend_r <= dec_ovf_s;
              state_r    <= CONVERT;
            end
          end
        end
        CONVERT: begin
          {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1;
          if (bit_cnt_r == CW'(DATA_W - 1)) begin
            state_r <= LOAD;
          end else begin
            bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        LOAD: begin
          disp_r     <= load_glyph_s;
          overflow_r <= ovf_pend_r;
          ready_r    <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Free-running prescaler and digit index for the multiplex scan
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r     <= '0;
      digit_idx_r <= '0;
    end else if (presc_r == PW'(SCAN_DIV - 1)) begin
      presc_r <= '0;
      if (digit_idx_r == IW'(NUM_DIGITS - 1)) begin
        digit_idx_r <= '0;
      end else begin
        digit_idx_r <= digit_idx_r + {{(IW-1){1'b0}}, 1'b1};
      end
    end else begin
      presc_r <= presc_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // One-hot enable for the current digit
  always_comb begin
    an_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_s[i] = (digit_idx_r == IW'(i));
    end
  end

  // Output register: seg and an move together, polarity applied here
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= {7{POL}};
      an_r  <= {NUM_DIGITS{POL}};
    end else begin
      seg_r <= disp_r[digit_idx_r] ^ {7{POL}};
      an_r  <= an_s ^ {NUM_DIGITS{POL}};
    end
  end

  assign ready    = ready_r;
  assign overflow = overflow_r;
  assign seg      = seg_r;
  assign an       = an_r;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench for seven_seg_scan_driver (NUM_DIGITS=4, DATA_W=14,
// SCAN_DIV=4). Stimulus pushes the expected display into a queue; a monitor
// pops on every ready rise and checks latency, overflow and each digit glyph
// as the scan presents it.
module tb_seven_seg_scan_driver;

  localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011;
  localparam logic [6:0] G3 = 7'b1001111, G4 = 7'b1100110, G7 = 7'b0000111;
  localparam logic [6:0] G9 = 7'b1101111, GA = 7'b1110111, GF = 7'b1110001;
  localparam logic [6:0] GDASH = 7'b1000000, GBLANK = 7'b0000000;

  typedef struct packed {
    logic            ovf;
    logic [3:0][6:0] g;
    logic [7:0]      low;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        value_valid = 1'b0;
  logic [13:0] value = 14'd0;
  logic        hex_mode = 1'b0;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        overflow;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic mon_busy = 1'b0;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .DATA_W(14), .SCAN_DIV(4), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .value_valid(value_valid), .value(value),
    .hex_mode(hex_mode), .ready(ready), .seg(seg), .an(an), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed load
  initial begin
    int        lowcnt;
    int        cc;
    logic      prev_ready;
    logic      collecting;
    exp_t      cur;
    logic [6:0] obs [4];
    logic [3:0] seen;
    lowcnt = 0; cc = 0; prev_ready = 1'b1; collecting = 1'b0;
    cur = '0; seen = 4'd0;
    for (int i = 0; i < 4; i++) obs[i] = 7'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ready = 1'b1; lowcnt = 0; collecting = 1'b0; mon_busy = 1'b0;
      end else if (collecting) begin
        cc++;
        for (int i = 0; i < 4; i++) begin
          if (an == (4'd1 << i)) begin
            obs[i] = seg;
            seen[i] = 1'b1;
          end
        end
        if (cc == 16) begin
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("digit%0d_seen", i), {31'd0, seen[i]}, 32'd1);
            chk($sformatf("digit%0d_glyph", i), {25'd0, obs[i]}, {25'd0, cur.g[i]});
          end
          chk("overflow_held", {31'd0, overflow}, {31'd0, cur.ovf});
          collecting = 1'b0;
          mon_busy = 1'b0;
        end
        prev_ready = ready;
      end else begin
        if (!ready) begin
          lowcnt++;
        end else if (!prev_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_load", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            chk("ready_low_cycles", lowcnt, {24'd0, cur.low});
            chk("overflow", {31'd0, overflow}, {31'd0, cur.ovf});
            collecting = 1'b1;
            mon_busy = 1'b1;
            cc = 0;
            seen = 4'd0;
          end
          lowcnt = 0;
        end
        prev_ready = ready;
      end
    end
  end

  task automatic send(input logic [13:0] v, input logic hx, input exp_t e, input logic drop);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
    exp_q.push_back(e);
    value = v; hex_mode = hx; value_valid = 1'b1;
    @(posedge clk); #1 value_valid = 1'b0;
    if (drop) begin
      @(negedge clk);
      chk("drop_ready_low", {31'd0, ready}, 32'd0);
      value = 14'h1234; hex_mode = 1'b0; value_valid = 1'b1;
      @(posedge clk); #1 value_valid = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_busy) got = 1'b1;
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic exp_t mk(input logic ovf, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0, input logic [7:0] low);
    exp_t e;
    e.ovf = ovf; e.g = {d3, d2, d1, d0}; e.low = low;
    return e;
  endfunction

  initial begin
    int bad;
    logic [6:0] lz;
`ifdef LEADING_ZERO_BLANK_EN
    lz = GBLANK;
`else
    lz = G0;
`endif
    // Reset state and scan stepping
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", {25'd0, seg}, 32'd0);
    chk("rst_an", {28'd0, an}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    for (int s = 0; s < 17; s++) begin
      @(negedge clk);
      chk($sformatf("scan_an_%0d", s), {28'd0, an}, {28'd0, 4'd1 << ((s / 4) % 4)});
    end

    // Display tests
    send(14'd1234,  1'b0, mk(1'b0, G1, G2, G3, G4, 8'd15), 1'b0);
    send(14'd10000, 1'b0, mk(1'b1, GDASH, GDASH, GDASH, GDASH, 8'd15), 1'b0);
    send(14'd9999,  1'b0, mk(1'b0, G9, G9, G9, G9, 8'd15), 1'b0);
    send(14'h3AF,   1'b1, mk(1'b0, G0, G3, GA, GF, 8'd1), 1'b1);
    send(14'd7,     1'b0, mk(1'b0, lz, lz, lz, G7, 8'd15), 1'b0);
    send(14'd0,     1'b0, mk(1'b0, lz, lz, lz, G0, 8'd15), 1'b0);

    // Reset during conversion aborts it
    @(negedge clk);
    value = 14'd1234; hex_mode = 1'b0; value_valid = 1'b1;
    @(posedge clk); #1 value_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_seg_blank", {25'd0, seg}, 32'd0);
    chk("abort_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (seg !== 7'd0 || ready !== 1'b1) bad++;
    end
    chk("abort_stays_blank", bad, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
